// File: rtl/rv32i_types.sv
// rv32i_types: shared RV32I definitions for the memory-access stage.
//   - ex_mem_pipeline_reg  : instruction bundle held in the EX/MEM register
//   - d_cache_pipeline_reg : completed bundle captured by MEM/WB
//   - mem_state_t          : memory-access FSM states
//   - funct3 load/store encodings and access-size helpers
package rv32i_types;

  localparam int XLEN = 32;

  localparam logic [2:0] lb  = 3'b000;
  localparam logic [2:0] lh  = 3'b001;
  localparam logic [2:0] lw  = 3'b010;
  localparam logic [2:0] lbu = 3'b100;
  localparam logic [2:0] lhu = 3'b101;
  localparam logic [2:0] sb  = 3'b000;
  localparam logic [2:0] sh  = 3'b001;
  localparam logic [2:0] sw  = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } mem_size_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic            mem_read;
    logic            mem_write;
    logic [2:0]      funct3;
    logic [XLEN-1:0] alu_out;
    logic [XLEN-1:0] rs2_out;
    logic [4:0]      rd;
    logic            load_regfile;
  } ex_mem_pipeline_reg;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] alu_out;
    logic [4:0]      rd;
    logic            load_regfile;
    logic [XLEN-1:0] mem_rdata;
    logic            misaligned;
  } d_cache_pipeline_reg;

  // Only funct3[1:0] sets the size (LBU/LHU share it with LB/LH); every
  // undefined encoding falls through to a word access.
  function automatic mem_size_t access_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return SZ_BYTE;
      2'b01:   return SZ_HALF;
      default: return SZ_WORD;
    endcase
  endfunction

  function automatic logic mem_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    case (access_size(f3))
      SZ_HALF: return lo[0];
      SZ_WORD: return (lo != 2'b00);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/p_mem_access_if.sv
// p_mem_access_if: data-cache request/response bus.
//   dmem_address/read/write/wmask/wdata : request (stage -> cache)
//   dmem_rdata/resp                     : response (cache -> stage)
// master = memory-access stage, slave = data cache.
interface p_mem_access_if;
  logic [31:0] dmem_address;
  logic        dmem_read;
  logic        dmem_write;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;

  modport master (
    output dmem_address, dmem_read, dmem_write, dmem_wmask, dmem_wdata,
    input  dmem_rdata, dmem_resp
  );

  modport slave (
    input  dmem_address, dmem_read, dmem_write, dmem_wmask, dmem_wdata,
    output dmem_rdata, dmem_resp
  );
endinterface

// File: rtl/p_load_align.sv
// p_load_align: combinational load formatter, also used by forwarding.
//   i_rdata   : raw 32-bit word from the cache
//   i_addr_lo : byte offset within the word
//   i_funct3  : load encoding (undefined encodings treated as LW)
//   o_result  : selected byte/half, sign- or zero-extended, or the full word
module p_load_align
  import rv32i_types::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_result
);

  logic [31:0]        w_shifted;
  logic signed [7:0]  w_byte;
  logic signed [15:0] w_half;

  assign w_shifted = i_rdata >> {i_addr_lo, 3'b000};
  assign w_byte    = w_shifted[7:0];
  assign w_half    = w_shifted[15:0];

  always_comb begin
    o_result = i_rdata;
    case (i_funct3)
      lb:      o_result = {{24{w_byte[7]}}, w_byte};
      lh:      o_result = {{16{w_half[15]}}, w_half};
      lbu:     o_result = {24'd0, w_byte};
      lhu:     o_result = {16'd0, w_half};
      default: o_result = i_rdata;
    endcase
  end

endmodule

// File: rtl/p_mem_access.sv
// p_mem_access: MEM stage of the RV32I pipeline.
//   clk, rst     : clock, synchronous active-high reset
//   in           : EX/MEM instruction bundle
//   pipe_advance : MEM/WB captures `out` on this edge
//   dmem         : data-cache bus (master side)
//   stall_mem    : holds the pipeline while a cache access is outstanding
//   out          : bundle for MEM/WB with formatted load data and misaligned flag
// Issues one aligned access per memory instruction, waits for the response,
// then holds the formatted result in DONE until the pipeline advances.
module p_mem_access
  import rv32i_types::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  ex_mem_pipeline_reg   in,
  input  logic                 pipe_advance,
  p_mem_access_if.master       dmem,
  output logic                 stall_mem,
  output d_cache_pipeline_reg  out
);

  mem_state_t  r_state;
  mem_state_t  w_state_n;

  logic        w_is_mem;
  logic        w_misaligned;
  logic        w_accept;
  logic [1:0]  w_lo;
  logic [3:0]  w_wmask;
  logic [31:0] w_wdata;
  logic [31:0] w_aligned;

  logic [31:0] r_addr;
  logic [1:0]  r_lo;
  logic [2:0]  r_funct3;
  logic        r_read;
  logic        r_write;
  logic [3:0]  r_wmask;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;

  assign w_lo         = in.alu_out[1:0];
  assign w_is_mem     = in.valid & (in.mem_read | in.mem_write);
  assign w_misaligned = w_is_mem & mem_misaligned(in.funct3, w_lo);
  assign w_accept     = w_is_mem & ~w_misaligned;

  always_comb begin
    w_wmask = 4'b1111;
    case (access_size(in.funct3))
      SZ_BYTE: w_wmask = 4'b0001 << w_lo;
      SZ_HALF: w_wmask = 4'b0011 << w_lo;
      default: w_wmask = 4'b1111;
    endcase
  end

  assign w_wdata = in.rs2_out << {w_lo, 3'b000};

  p_load_align u_load_align (
    .i_rdata   (dmem.dmem_rdata),
    .i_addr_lo (r_lo),
    .i_funct3  (r_funct3),
    .o_result  (w_aligned)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    stall_mem = 1'b0;
    case (r_state)
      IDLE: begin
        stall_mem = w_accept;
        if (w_accept) w_state_n = BUSY;
      end
      BUSY: begin
        stall_mem = 1'b1;
        if (dmem.dmem_resp) w_state_n = DONE;
      end
      DONE: begin
        if (pipe_advance) w_state_n = IDLE;
      end
      default: w_state_n = IDLE;
    endcase
  end

  // ---- request latch: fields move only on IDLE->BUSY, data on response ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr   <= '0;
      r_lo     <= '0;
      r_funct3 <= '0;
      r_read   <= 1'b0;
      r_write  <= 1'b0;
      r_wmask  <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
    end else begin
      if (r_state == IDLE && w_accept) begin
        r_addr   <= {in.alu_out[31:2], 2'b00};
        r_lo     <= w_lo;
        r_funct3 <= in.funct3;
        r_read   <= in.mem_read;
        r_write  <= in.mem_write & ~in.mem_read;
        r_wmask  <= in.mem_read ? 4'b0000 : w_wmask;
        r_wdata  <= in.mem_read ? 32'd0 : w_wdata;
      end
      if (r_state == BUSY && dmem.dmem_resp) r_rdata <= w_aligned;
    end
  end

  assign dmem.dmem_address = r_addr;
  assign dmem.dmem_read    = (r_state == BUSY) & r_read;
  assign dmem.dmem_write   = (r_state == BUSY) & r_write;
  assign dmem.dmem_wmask   = r_wmask;
  assign dmem.dmem_wdata   = r_wdata;

  // ---- MEM/WB bundle ----
  always_comb begin
    out              = '0;
    out.valid        = in.valid;
    out.pc           = in.pc;
    out.alu_out      = in.alu_out;
    out.rd           = in.rd;
    out.load_regfile = in.load_regfile & ~w_misaligned;
    out.mem_rdata    = (r_state == DONE) ? r_rdata : 32'd0;
    out.misaligned   = w_misaligned;
  end

endmodule

// File: tb/tb_p_mem_access.sv
module tb_p_mem_access;
  import rv32i_types::*;

  logic                clk;
  logic                rst;
  ex_mem_pipeline_reg  in;
  logic                pipe_advance;
  logic                stall_mem;
  d_cache_pipeline_reg out;

  p_mem_access_if dmem_bus ();

  p_mem_access dut (
    .clk          (clk),
    .rst          (rst),
    .in           (in),
    .pipe_advance (pipe_advance),
    .dmem         (dmem_bus),
    .stall_mem    (stall_mem),
    .out          (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic int ref_size(input logic [2:0] f3);
    if (f3 == 3'b000 || f3 == 3'b100) return 1;
    if (f3 == 3'b001 || f3 == 3'b101) return 2;
    return 4;
  endfunction

  function automatic bit ref_misal(input logic [2:0] f3, input logic [31:0] addr);
    return (addr % ref_size(f3)) != 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] rdata);
    int sz = ref_size(f3);
    longint v;
    longint lim;
    logic [63:0] r;
    if (sz == 4) return rdata;
    lim = longint'(1) << (8 * sz);
    v = (longint'(rdata) >> (8 * (addr % 4))) % lim;
    if ((f3 == 3'b000 || f3 == 3'b001) && v >= lim / 2) v = v - lim;
    r = v;
    return r[31:0];
  endfunction

  function automatic logic [31:0] ref_mask(input logic [2:0] f3, input logic [31:0] addr);
    int m = ((1 << ref_size(f3)) - 1) << (addr % 4);
    return m;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [31:0] rs2, input logic [31:0] addr);
    logic [63:0] r;
    r = longint'(rs2) << (8 * (addr % 4));
    return r[31:0];
  endfunction

  // ---------------- stimulus ----------------
  task automatic drive_op(input bit is_load, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] rs2);
    in.valid        = 1'b1;
    in.pc           = $urandom;
    in.mem_read     = is_load;
    in.mem_write    = ~is_load;
    in.funct3       = f3;
    in.alu_out      = addr;
    in.rs2_out      = rs2;
    in.rd           = 5'($urandom_range(1, 31));
    in.load_regfile = is_load;
  endtask

  task automatic run_mem(input string nm, input bit is_load, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] rs2,
                         input logic [31:0] rdata, input int k, input int hold);
    logic [31:0] exp_rd;
    step();
    drive_op(is_load, f3, addr, rs2);
    @(negedge clk);
    if (ref_misal(f3, addr)) begin
      chk({nm, ".mis_stall"}, 32'(stall_mem), 0);
      chk({nm, ".mis_flag"}, 32'(out.misaligned), 1);
      chk({nm, ".mis_lr"}, 32'(out.load_regfile), 0);
      chk({nm, ".mis_rdata"}, out.mem_rdata, 0);
      chk({nm, ".mis_req"}, 32'(dmem_bus.dmem_read | dmem_bus.dmem_write), 0);
      step();
      @(negedge clk);
      chk({nm, ".mis_stall2"}, 32'(stall_mem), 0);
      chk({nm, ".mis_req2"}, 32'(dmem_bus.dmem_read | dmem_bus.dmem_write), 0);
      pipe_advance = 1'b1;
      step();
      pipe_advance = 1'b0;
      in.valid = 1'b0;
      return;
    end
    chk({nm, ".c0_stall"}, 32'(stall_mem), 1);
    chk({nm, ".c0_req"}, 32'(dmem_bus.dmem_read | dmem_bus.dmem_write), 0);
    for (int c = 1; c <= k; c++) begin
      step();
      if (c == k) begin
        dmem_bus.dmem_rdata = rdata;
        dmem_bus.dmem_resp  = 1'b1;
      end
      @(negedge clk);
      chk({nm, ".rd"}, 32'(dmem_bus.dmem_read), 32'(is_load));
      chk({nm, ".wr"}, 32'(dmem_bus.dmem_write), 32'(!is_load));
      chk({nm, ".addr"}, dmem_bus.dmem_address, {addr[31:2], 2'b00});
      chk({nm, ".mask"}, 32'(dmem_bus.dmem_wmask), is_load ? 32'd0 : ref_mask(f3, addr));
      if (!is_load) chk({nm, ".wdata"}, dmem_bus.dmem_wdata, ref_wdata(rs2, addr));
      chk({nm, ".busy_stall"}, 32'(stall_mem), 1);
    end
    step();
    dmem_bus.dmem_resp  = 1'b0;
    dmem_bus.dmem_rdata = $urandom;
    exp_rd = ref_load(f3, addr, rdata);
    @(negedge clk);
    chk({nm, ".done_stall"}, 32'(stall_mem), 0);
    chk({nm, ".done_req"}, 32'(dmem_bus.dmem_read | dmem_bus.dmem_write), 0);
    chk({nm, ".done_mis"}, 32'(out.misaligned), 0);
    chk({nm, ".done_lr"}, 32'(out.load_regfile), 32'(is_load));
    if (is_load) chk({nm, ".ldata"}, out.mem_rdata, exp_rd);
    for (int h = 0; h < hold; h++) begin
      step();
      dmem_bus.dmem_rdata = $urandom;
      @(negedge clk);
      chk({nm, ".hold_stall"}, 32'(stall_mem), 0);
      chk({nm, ".hold_req"}, 32'(dmem_bus.dmem_read | dmem_bus.dmem_write), 0);
      if (is_load) chk({nm, ".hold_data"}, out.mem_rdata, exp_rd);
    end
    pipe_advance = 1'b1;
    step();
    pipe_advance = 1'b0;
    in.valid = 1'b0;
    @(negedge clk);
    chk({nm, ".idle_stall"}, 32'(stall_mem), 0);
    chk({nm, ".idle_req"}, 32'(dmem_bus.dmem_read | dmem_bus.dmem_write), 0);
    chk({nm, ".idle_rdata"}, out.mem_rdata, 0);
  endtask

  task automatic run_alu(input string nm);
    logic [31:0] pc;
    logic [4:0]  rd;
    step();
    pc = $urandom;
    rd = 5'($urandom);
    in = '0;
    in.valid = 1'b1;
    in.pc = pc;
    in.alu_out = $urandom;
    in.rd = rd;
    in.load_regfile = 1'b1;
    pipe_advance = 1'b1;
    @(negedge clk);
    chk({nm, ".stall"}, 32'(stall_mem), 0);
    chk({nm, ".valid"}, 32'(out.valid), 1);
    chk({nm, ".pc"}, out.pc, pc);
    chk({nm, ".rd"}, 32'(out.rd), 32'(rd));
    chk({nm, ".lr"}, 32'(out.load_regfile), 1);
    chk({nm, ".req"}, 32'(dmem_bus.dmem_read | dmem_bus.dmem_write), 0);
    step();
    pipe_advance = 1'b0;
    in.valid = 1'b0;
  endtask

  logic [2:0] ld_f3 [8] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
  logic [2:0] st_f3 [4] = '{3'b000, 3'b001, 3'b010, 3'b011};

  initial begin
    rst = 1'b1;
    in = '0;
    pipe_advance = 1'b0;
    dmem_bus.dmem_rdata = '0;
    dmem_bus.dmem_resp  = 1'b0;
    repeat (2) step();
    @(negedge clk);
    chk("rst.stall", 32'(stall_mem), 0);
    chk("rst.rd", 32'(dmem_bus.dmem_read), 0);
    chk("rst.wr", 32'(dmem_bus.dmem_write), 0);
    chk("rst.addr", dmem_bus.dmem_address, 0);
    chk("rst.mask", 32'(dmem_bus.dmem_wmask), 0);
    chk("rst.wdata", dmem_bus.dmem_wdata, 0);
    chk("rst.valid", 32'(out.valid), 0);
    chk("rst.rdata", out.mem_rdata, 0);
    step();
    rst = 1'b0;

    run_mem("sw", 1'b0, sw, 32'h1000, 32'hDEADBEEF, 32'h0, 3, 0);
    run_mem("sb", 1'b0, sb, 32'h1003, 32'h000000A5, 32'h0, 1, 0);
    run_mem("lb", 1'b1, lb, 32'h2001, 32'h0, 32'h12348000, 1, 0);
    run_mem("lbu", 1'b1, lbu, 32'h2001, 32'h0, 32'h12348000, 2, 0);
    run_mem("lh", 1'b1, lh, 32'h2002, 32'h0, 32'h12348000, 1, 0);
    run_mem("lw_mis", 1'b1, lw, 32'h3002, 32'h0, 32'h0, 1, 0);
    run_mem("lw_hold", 1'b1, lw, 32'h3004, 32'h0, 32'hCAFEF00D, 2, 3);
    run_alu("alu");

    // reset while BUSY, then a stray response
    step();
    drive_op(1'b1, lw, 32'h4000, 32'h0);
    @(negedge clk);
    chk("rb.c0_stall", 32'(stall_mem), 1);
    step();
    step();
    rst = 1'b1;
    in.valid = 1'b0;
    @(negedge clk);
    chk("rb.c2_rd", 32'(dmem_bus.dmem_read), 1);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rb.rd_drop", 32'(dmem_bus.dmem_read), 0);
    chk("rb.stall", 32'(stall_mem), 0);
    step();
    dmem_bus.dmem_rdata = 32'h55AA55AA;
    dmem_bus.dmem_resp  = 1'b1;
    step();
    dmem_bus.dmem_resp  = 1'b0;
    @(negedge clk);
    chk("stray.stall", 32'(stall_mem), 0);
    chk("stray.req", 32'(dmem_bus.dmem_read | dmem_bus.dmem_write), 0);
    chk("stray.rdata", out.mem_rdata, 0);
    chk("stray.addr", dmem_bus.dmem_address, 0);
    chk("stray.mask", 32'(dmem_bus.dmem_wmask), 0);

    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        run_alu("r_alu");
      end else if ($urandom_range(0, 1) == 1) begin
        run_mem("r_ld", 1'b1, ld_f3[$urandom_range(0, 7)], $urandom, $urandom, $urandom,
                int'($urandom_range(1, 4)), int'($urandom_range(0, 3)));
      end else begin
        run_mem("r_st", 1'b0, st_f3[$urandom_range(0, 3)], $urandom, $urandom, $urandom,
                int'($urandom_range(1, 4)), int'($urandom_range(0, 3)));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/p_mem_access.md
# p_mem_access

Memory-access stage of the pipelined RV32I core. Takes the instruction held in the EX/MEM pipeline register, issues at most one aligned read or write to the data cache, and stalls the pipeline until the cache responds. It then formats load data (byte/half select, sign or zero extension) and presents the completed `d_cache_pipeline_reg` bundle, loaded into the MEM/WB pipeline register on pipeline advance.

## Interface
- No parameters; widths fixed by `rv32i_types` (XLEN 32).
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `in`  in  `ex_mem_pipeline_reg`  instruction bundle: `valid`, `mem_read`, `mem_write`, `funct3[2:0]`, `alu_out[31:0]` (address), `rs2_out[31:0]`, `rd[4:0]`, `load_regfile`, plus pass-through fields.
- `pipe_advance`  in  1  global advance from the hazard unit; high means MEM/WB captures `out` this edge.
- `dmem_address`  out  32  word-aligned address (`{addr[31:2],2'b00}`).
- `dmem_read` / `dmem_write`  out  1  request strobes, mutually exclusive.
- `dmem_wmask`  out  4  byte enables.
- `dmem_wdata`  out  32  lane-shifted store data.
- `dmem_rdata`  in  32  read data, valid with `dmem_resp`.
- `dmem_resp`  in  1  one-cycle completion pulse.
- `stall_mem`  out  1  to the hazard unit; freezes all upstream registers and blocks `pipe_advance`.
- `out`  out  `d_cache_pipeline_reg`  pass-through fields plus `mem_rdata[31:0]` (formatted) and `misaligned`.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - `in.valid` and a memory op, aligned: latch address, mask, wdata and op; go BUSY; `stall_mem`=1.
  - Non-memory or invalid: combinational pass-through, `stall_mem`=0.
- BUSY: hold `dmem_read`/`dmem_write` and all request fields stable; `stall_mem`=1. On `dmem_resp`: capture formatted `dmem_rdata`; go DONE.
- DONE: no request; `stall_mem`=0; `out` uses the captured data. On `pipe_advance`: go IDLE. Otherwise hold DONE and do not reissue.
- Masks: SB → `4'b0001<<addr[1:0]`; SH → `4'b0011<<addr[1:0]`; SW → `4'b1111`. `wdata = rs2_out << (8*addr[1:0])`.
- Loads: select the byte/half at `addr[1:0]`. LB/LH sign-extend; LBU/LHU zero-extend; LW passes through. Reads drive `dmem_wmask`=0.
- Misaligned (LH/LHU/SH with `addr[0]`; LW/SW with `addr[1:0]!=0`):
  - No request; stay IDLE.
  - `out.misaligned`=1, `out.load_regfile`=0, `mem_rdata`=0, `stall_mem`=0.
- `dmem_resp` outside BUSY is ignored.
- Undefined `funct3` on a memory op is treated as a word access.

## Timing
- Reset: state IDLE, all request outputs 0, `stall_mem`=0, captured data 0. `out` is the pass-through of `in`; when `in.valid`=0, `out` carries `valid`=0.
- Reset mid-BUSY: request strobes drop on the next edge. The cache must tolerate an abandoned request. No response is consumed afterward.
- Memory op accepted at edge 0. Request visible cycle 1. Response in cycle k≥1 → DONE in cycle k+1, `stall_mem` low.
  - Minimum stall: 2 cycles (cycles 0 and 1 when resp arrives in cycle 1).
  - MEM/WB captures at the first advance edge in DONE.
- Request fields change only on the IDLE→BUSY edge.
- Non-memory instructions: zero added latency.

## Structure
- `rv32i_types` holds:
  - `ex_mem_pipeline_reg` and `d_cache_pipeline_reg` (fields listed above).
  - `mem_state_t` enum.
  - `funct3` constants `lb`, `lh`, `lw`, `lbu`, `lhu`, `sb`, `sh`, `sw`.
- One sub-module, `p_load_align`: combinational byte/half select plus extension (rdata, `addr[1:0]`, `funct3` → 32-bit result). It is reused by the forwarding logic.

## Test plan
- SW `0x1000`, rs2=`0xDEADBEEF`, resp at cycle 3 → `dmem_write`=1 in cycles 1–3, mask `1111`, wdata `0xDEADBEEF`, `stall_mem` high cycles 0–3, low cycle 4.
- SB `0x1003`, rs2=`0x000000A5` → address `0x1000`, mask `1000`, wdata `0xA5000000`.
- LB `0x2001`, rdata `0x12348000` → `mem_rdata`=`0xFFFFFF80`. LBU at the same address → `0x00000080`. LH `0x2002` → `0x00001234`.
- LW `0x3002` → no request, `misaligned`=1, `load_regfile`=0, `stall_mem` never asserted.
- LW resp arrives while `pipe_advance`=0 for 3 cycles → state stays DONE, no second `dmem_read`, data stable, IDLE after the advance edge.
- `rst` asserted in BUSY cycle 2 → `dmem_read`=0 next cycle, state IDLE; a later stray `dmem_resp` leaves all outputs unchanged.
